// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronised rx, mid-bit sampling, parity/framing/overrun.
// Line config is latched when a start edge is accepted.
module uart_rx_engine #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [19:0] k,
  input  logic        eight,
  input  logic        pen,
  input  logic        ohel,
  input  logic        rd_clr,
  output logic [7:0]  rx_data,
  output logic        rxrdy,
  output logic        perr,
  output logic        ferr,
  output logic        ovf
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [NS-1:0] sync_q;
  logic        rx_sync;
  logic        seen_hi;
  logic [19:0] cnt;
  logic [19:0] k_q;
  logic        eight_q;
  logic        pen_q;
  logic        ohel_q;
  logic [3:0]  bidx;
  logic [8:0]  sh;
  logic [19:0] target;
  logic        tick;
  logic        clr;
  logic [3:0]  nbits;
  logic [8:0]  val;
  logic [7:0]  data;
  logic        done_evt;

  assign rx_sync = sync_q[NS-1];
  assign nbits   = 4'd7 + {3'b0, eight_q} + {3'b0, pen_q};
  assign target  = (state == START) ? (k_q >> 1) : k_q;
  assign tick    = (cnt + 20'd1) == target;
  assign clr     = (state_d != state) || tick || (state == IDLE);
  // Shifted in at the MSB, so the frame lands in the top nbits.
  assign val     = sh >> (4'd9 - nbits);
  assign data    = eight_q ? val[7:0] : {1'b0, val[6:0]};
  assign done_evt = (state == STOP) && tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[NS-2:0], rx};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (!rx_sync && seen_hi) state_d = START;
      end
      START: begin
        if (tick) state_d = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (tick && (bidx + 4'd1 == nbits)) state_d = STOP;
      end
      STOP: begin
        if (tick) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_hi <= 1'b1;
      cnt     <= '0;
      bidx    <= '0;
      sh      <= '0;
      k_q     <= 20'd4;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
    end else begin
      // A low stop bit must not re-arm IDLE until the line goes high.
      seen_hi <= rx_sync || ((state == IDLE) && seen_hi);
      cnt     <= clr ? 20'd0 : cnt + 20'd1;
      if ((state == IDLE) && (state_d == START)) begin
        k_q     <= (k < 20'd4) ? 20'd4 : k;
        eight_q <= eight;
        pen_q   <= pen;
        ohel_q  <= ohel;
      end
      if ((state == START) && tick) bidx <= '0;
      if ((state == DATA) && tick) begin
        sh   <= {rx_sync, sh[8:1]};
        bidx <= bidx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data <= '0;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (done_evt) begin
      rx_data <= data;
      perr    <= pen_q && ((^val) != ohel_q);
      ferr    <= ~rx_sync;
      ovf     <= rxrdy && !rd_clr;
      rxrdy   <= 1'b1;
    end else if (rd_clr) begin
      rxrdy <= 1'b0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine.
// Frames are driven on rx at falling edges; outputs checked off-edge.
module tb_uart_rx_engine;

  logic        clk;
  logic        reset;
  logic        rx;
  logic [19:0] k;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic        rd_clr;
  logic [7:0]  rx_data;
  logic        rxrdy;
  logic        perr;
  logic        ferr;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  uart_rx_engine #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .k       (k),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .rd_clr  (rd_clr),
    .rx_data (rx_data),
    .rxrdy   (rxrdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear();
    rd_clr = 1'b1;
    @(negedge clk);
    rd_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] bits, input int n,
                            input int bt, input logic stop);
    rx = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (bt) @(negedge clk);
    end
    rx = stop;
    repeat (bt) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    reset  = 1'b1;
    rx     = 1'b1;
    k      = 20'd16;
    eight  = 1'b1;
    pen    = 1'b0;
    ohel   = 1'b0;
    rd_clr = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("rst_data", {24'd0, rx_data}, 32'h0);
    chk("rst_flags", {27'd0, rxrdy, perr, ferr, ovf}, 32'h0);
    idle(3);
    reset = 1'b1;
    idle(6);

    // 8N1 0x55, rxrdy 153 clocks after the rx_sync fall
    fork
      send_frame(9'h055, 8, 16, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 chk("lat_before", {31'd0, rxrdy}, 32'd0);
        @(posedge clk);
        #1 chk("lat_at", {31'd0, rxrdy}, 32'd1);
      end
    join
    chk("d55", {24'd0, rx_data}, 32'h55);
    chk("f55", {29'd0, perr, ferr, ovf}, 32'h0);
    clear();
    chk("rdclr", {30'd0, rxrdy, ovf}, 32'h0);
    idle(4);

    // 7 bits + even parity
    eight = 1'b0;
    pen   = 1'b1;
    ohel  = 1'b0;
    send_frame(9'h041, 8, 16, 1'b1);
    idle(4);
    chk("p7e0_d", {24'd0, rx_data}, 32'h41);
    chk("p7e0_p", {31'd0, perr}, 32'd0);
    clear();
    send_frame(9'h0C1, 8, 16, 1'b1);
    idle(4);
    chk("p7e1_d", {24'd0, rx_data}, 32'h41);
    chk("p7e1_p", {31'd0, perr}, 32'd1);
    clear();
    ohel = 1'b1;
    send_frame(9'h041, 8, 16, 1'b1);
    idle(4);
    chk("p7o0_d", {24'd0, rx_data}, 32'h41);
    chk("p7o0_p", {31'd0, perr}, 32'd1);
    clear();

    // 4-clock glitch is a false start
    eight = 1'b1;
    pen   = 1'b0;
    ohel  = 1'b0;
    rx    = 1'b0;
    idle(4);
    rx    = 1'b1;
    idle(40);
    chk("glitch", {31'd0, rxrdy}, 32'd0);
    send_frame(9'h0A3, 8, 16, 1'b1);
    idle(4);
    chk("a3_d", {24'd0, rx_data}, 32'hA3);
    chk("a3_r", {31'd0, rxrdy}, 32'd1);
    clear();

    // stop bit low
    send_frame(9'h00F, 8, 16, 1'b0);
    idle(20);
    chk("fe_d", {24'd0, rx_data}, 32'h0F);
    chk("fe_f", {31'd0, ferr}, 32'd1);
    clear();
    send_frame(9'h05A, 8, 16, 1'b1);
    idle(4);
    chk("fe_clr_d", {24'd0, rx_data}, 32'h5A);
    chk("fe_clr_f", {31'd0, ferr}, 32'd0);
    clear();

    // overrun
    send_frame(9'h011, 8, 16, 1'b1);
    send_frame(9'h022, 8, 16, 1'b1);
    idle(4);
    chk("ov_d", {24'd0, rx_data}, 32'h22);
    chk("ov_f", {30'd0, rxrdy, ovf}, 32'h3);
    clear();
    chk("ov_clr", {30'd0, rxrdy, ovf}, 32'h0);
    send_frame(9'h044, 8, 16, 1'b1);
    idle(4);
    fork
      send_frame(9'h033, 8, 16, 1'b1);
      begin
        repeat (154) @(negedge clk);
        rd_clr = 1'b1;
        @(negedge clk);
        rd_clr = 1'b0;
      end
    join
    idle(2);
    chk("coin_d", {24'd0, rx_data}, 32'h33);
    chk("coin_f", {30'd0, rxrdy, ovf}, 32'h2);

    // reset mid-frame at data bit 3
    fork
      send_frame(9'h0C3, 8, 16, 1'b1);
      begin
        repeat (70) @(negedge clk);
        reset = 1'b0;
        #2;
        chk("mid_rst_d", {24'd0, rx_data}, 32'h0);
        chk("mid_rst_f", {27'd0, rxrdy, perr, ferr, ovf}, 32'h0);
      end
    join
    idle(2);
    reset = 1'b1;
    idle(30);
    chk("mid_rst_none", {31'd0, rxrdy}, 32'd0);
    send_frame(9'h0C3, 8, 16, 1'b1);
    idle(4);
    chk("c3_d", {24'd0, rx_data}, 32'hC3);
    chk("c3_r", {31'd0, rxrdy}, 32'd1);
    clear();

    // k below 4 clamps to 4 clocks per bit
    k = 20'd2;
    send_frame(9'h096, 8, 4, 1'b1);
    idle(4);
    chk("k2_d", {24'd0, rx_data}, 32'h96);
    chk("k2_f", {28'd0, rxrdy, perr, ferr, ovf}, 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Receive half of the class UART. Deserialises an asynchronous serial line into bytes.
- Uses the same 20-bit baud divisor `k` and the same line-config inputs (`eight`, `pen`, `ohel`) as the transmit path.
- Sits between the rx pin and the processor-side status/data registers.
- Provides mid-bit sampling, false-start rejection, and parity, framing and overrun flags.

Parameters:
- SYNC_STAGES, 2, number of flops in the rx input synchroniser (minimum 2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- rx  input  1  serial line, idle high
- k  input  20  clocks per bit time (baud decoder output)
- eight  input  1  1 = 8 data bits, 0 = 7 data bits
- pen  input  1  parity enable
- ohel  input  1  parity sense: 1 = odd, 0 = even
- rd_clr  input  1  one-cycle pulse; processor has read rx_data
- rx_data  output  8  last received character (bit 7 forced 0 in 7-bit mode)
- rxrdy  output  1  character available
- perr  output  1  parity error for the character in rx_data
- ferr  output  1  framing error (stop bit sampled low)
- ovf  output  1  overrun: a new character completed while rxrdy was still set

Behaviour:
- Reset (reset = 0) forces these values immediately, independent of clk:
  - rx_data = 0, rxrdy = 0, perr = 0, ferr = 0, ovf = 0
  - state = IDLE, counters = 0, synchroniser flops = 1
- rx_sync is rx delayed by SYNC_STAGES clocks. All timing below is relative to rx_sync.
- Bit-time counter: cleared on every state entry and after every sample; increments each clock. A sample fires when the count reaches the target, i.e. exactly target clocks after the clear.
- Targets:
  - START state: half = k >> 1
  - all other states: full = k
  - k < 4 is clamped to 4, so half is never 0.
- Frame length: nbits = 7 + eight + pen (range 7..9). Data is LSB first; the parity bit, when enabled, is last.
- IDLE:
  - rx_sync = 0 -> START.
  - rx_sync held low through reset release is treated as a start edge; the false-start check covers this case.
- START: at the half sample:
  - rx_sync = 1 -> false start, return to IDLE, no flags change.
  - rx_sync = 0 -> DATA, bit index = 0.
- DATA: at each full sample:
  - shift rx_sync into the shift register MSB and increment the bit index.
  - after the nbits-th sample -> STOP.
- STOP: at the full sample -> DONE. Record ferr_n = ~rx_sync.
- DONE (one clock), then -> IDLE:
  - Right-justify the shift register into rx_data: 7-bit mode gives rx_data[7] = 0; the parity bit is excluded.
  - perr = pen & (XOR(data bits, parity bit) != ohel). perr = 0 when pen = 0.
  - ferr = ferr_n.
  - ovf = rxrdy (value before this update).
  - rxrdy = 1.
  - rx_data, perr, ferr and ovf update together on this single clock.
- Re-arm: after DONE, IDLE accepts a new start edge on the next clock. A stop bit sampled low does not by itself start a new frame. IDLE only arms once rx_sync has been seen high for at least 1 clock.
- rd_clr:
  - clears rxrdy and ovf on the next edge.
  - if rd_clr coincides with DONE, DONE wins: rxrdy = 1, ovf = 0 because the old character was consumed.
  - perr and ferr persist until the next DONE.
- Line-config inputs (`k`, `eight`, `pen`, `ohel`) are sampled at START entry and held for the frame. Mid-frame changes do not affect the current frame.
- Reset asserted mid-frame aborts the frame; nothing is delivered.

Test Plan:
- k = 16, 8N1 (eight = 1, pen = 0), send 0x55 -> rx_data = 0x55, rxrdy rises 153 clocks after the rx_sync fall, perr = ferr = ovf = 0.
- k = 16, 7 bits, even parity, send 0x41 with parity bit 0 -> rx_data = 0x41, perr = 0. Repeat with parity bit 1 -> perr = 1. Repeat with ohel = 1 and parity 0 -> perr = 1.
- 4-clock low glitch on rx, k = 16 -> sampled high at half-bit, state back to IDLE, rxrdy stays 0. A following valid 0xA3 frame is received correctly.
- Stop bit driven low, 0x0F -> rx_data = 0x0F, ferr = 1. Next clean frame -> ferr = 0.
- Two back-to-back frames 0x11, 0x22 with no rd_clr -> rx_data = 0x22, ovf = 1. Then rd_clr -> rxrdy = 0, ovf = 0. rd_clr on the same clock as DONE -> rxrdy = 1, ovf = 0.
- reset pulled low at data bit 3 of a frame -> all outputs 0 asynchronously. After release, a clean 0xC3 frame is received correctly; k = 2 is clamped to 4 and still receives correctly.
